cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
Shares the single physical-memory / L2 line port between the LC-3b instruction cache and data cache.
- Sits below both L1 caches, above memory.
- Accepts one outstanding line transaction at a time.
- Resolves simultaneous misses round-robin.
- Returns the fetched line with a one-cycle response pulse to the granted cache.

Parameters:
ADDR_W, 16, byte address width (lc3b_word).
LINE_W, 128, cache line width in bits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
i_read  in  1  icache line-read request; held until i_resp.
i_addr  in  ADDR_W  icache line address.
i_rdata  out  LINE_W  line returned to icache; valid only while i_resp=1.
i_resp  out  1  one-cycle completion pulse to icache.
d_read  in  1  dcache line-read request; held until d_resp.
d_write  in  1  dcache line-writeback request; held until d_resp.
d_addr  in  ADDR_W  dcache line address.
d_wdata  in  LINE_W  writeback line.
d_rdata  out  LINE_W  line returned to dcache; valid only while d_resp=1.
d_resp  out  1  one-cycle completion pulse to dcache.
mem_read  out  1  memory line read.
mem_write  out  1  memory line write.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  LINE_W  memory write line.
mem_rdata  in  LINE_W  memory read line; valid with mem_resp.
mem_resp  in  1  memory completion, one cycle.

Behaviour:
- Reset (asynchronous, rst_n=0, any state): state=IDLE; last_grant=ICACHE; addr/wdata/line buffers=0; all outputs 0.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE arbitration, evaluated at the clock edge:
  - Only one of icache / dcache requesting: grant it.
  - Both requesting: grant the one opposite last_grant. Reset value means the first tie goes to dcache.
  - On grant: latch addr; for a dcache write also latch wdata and a write flag; update last_grant.
  - Go to SERVE_I or SERVE_D.
- SERVE_x:
  - mem_read / mem_write decoded from registered state and write flag; no combinational path from requester inputs to mem_*.
  - mem_addr and mem_wdata come from the latched registers.
  - Remain until mem_resp=1.
  - At that edge capture mem_rdata into the line buffer (writes capture too; contents don't-care) and go to RESP_x.
- RESP_x:
  - x_resp=1 for exactly one cycle; x_rdata = line buffer; mem_read = mem_write = 0.
  - Next state IDLE unconditionally.
  - The requester drops its request on seeing resp, so IDLE never re-grants a serviced request.
- Latency: request present at edge N → mem_read/mem_write high from cycle N+1; mem_resp in cycle M → x_resp in cycle M+1 → IDLE in cycle M+2.
  - Arbitration overhead is 2 cycles per transaction.
- Boundary cases:
  - mem_resp while IDLE or RESP_x: ignored.
  - Requester deasserts during SERVE_x (protocol violation): transaction completes and resp still pulses.
  - d_read and d_write both high (illegal): treated as a write.
  - Requester changes addr while granted: no effect, the latched copy is used.
  - Back-to-back requests from one cache with the other idle: no forced alternation.
  - Reset mid-SERVE: the memory-side transaction is abandoned, and a late mem_resp after reset is ignored.
- Outputs i_rdata and d_rdata are both driven from the shared line buffer. Only the matching resp qualifies them.

Decomposition:
- lc3b_types package: add lc3b_c_line (logic [127:0]) and a 1-bit requester enum (ICACHE / DCACHE) for last_grant.
- FSM state enum: local to the module.
- Line buffer and the address / wdata latches: instances of the existing generic register module with width parameter.
- No other sub-module.

Test Plan:
1. i_read=1, i_addr=16'h1230; memory answers mem_resp after 3 cycles with 128'hA5A5…A5 → mem_read high with mem_addr=16'h1230; one-cycle i_resp with i_rdata=128'hA5A5…A5; d_resp stays 0.
2. d_write=1, d_addr=16'h4000, d_wdata=128'h0123…CDEF → mem_write high with mem_addr=16'h4000, mem_wdata=128'h0123…CDEF; one-cycle d_resp; mem_read never asserted.
3. After reset, i_read and d_read asserted in the same cycle (addr 16'h0010 / 16'h0020), both held → dcache served first (mem_addr=16'h0020), then icache (16'h0010). Repeat the tie → icache first this time.
4. i_read asserted continuously across 3 transactions, d idle → three icache services, each with exactly a 2-cycle gap between mem_resp and the next mem_read.
5. Assert rst_n=0 during SERVE_D, then deliver a late mem_resp after release → all outputs 0 immediately on reset; no d_resp; FSM in IDLE.
6. mem_resp pulsed while IDLE; i_addr changed mid-SERVE_I → no resp pulse from the stray mem_resp; mem_addr keeps the originally latched address.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the L1-to-memory line arbiter.
//   lc3b_word   : 16-bit LC-3b byte address
//   lc3b_c_line : one 128-bit cache line
//   requester_e : which L1 cache owns the memory port (round-robin history)
package cache_mem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and memory line-port signals seen by the arbiter.
//   slave  : arbiter side (takes cache requests and memory responses,
//            drives cache responses and memory commands)
//   master : environment side (caches + memory)
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_mem_arbiter_register.sv
// Generic load-enabled register, asynchronously cleared.
//   clk, rst_n : clock, async active-low clear to zero
//   load       : capture 'in' on the rising edge
//   in / out   : data in, registered data out
module register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out = data_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single memory line port between the icache and the dcache.
// One line transaction is outstanding at a time; simultaneous misses are
// resolved round-robin and the fetched line is returned with a one-cycle
// resp pulse to the granted cache.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : icache / dcache request-response and memory command signals
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  requester_e last_grant_q, last_grant_d;
  logic       wr_q, wr_d;

  logic              addr_ld;
  logic              wdata_ld;
  logic              line_ld;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;

  logic i_req;
  logic d_req;

  assign i_req = bus.i_read;
  // A simultaneous d_read/d_write is treated as a writeback.
  assign d_req = bus.d_read | bus.d_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_ld      = 1'b0;
    wdata_ld     = 1'b0;
    line_ld      = 1'b0;
    addr_in      = bus.i_addr;

    case (state_q)
      IDLE: begin
        // On a tie the cache that was not granted last time wins.
        if (i_req && (!d_req || (last_grant_q == DCACHE))) begin
          state_d      = SERVE_I;
          last_grant_d = ICACHE;
          wr_d         = 1'b0;
          addr_ld      = 1'b1;
          addr_in      = bus.i_addr;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = DCACHE;
          wr_d         = bus.d_write;
          addr_ld      = 1'b1;
          addr_in      = bus.d_addr;
          wdata_ld     = bus.d_write;
        end
      end
      SERVE_I: begin
        if (bus.mem_resp) begin
          line_ld = 1'b1;
          state_d = RESP_I;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) begin
          line_ld = 1'b1;
          state_d = RESP_D;
        end
      end
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ICACHE;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
    end
  end

  register #(.WIDTH(ADDR_W)) addr_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (addr_ld),
    .in    (addr_in),
    .out   (addr_q)
  );

  register #(.WIDTH(LINE_W)) wdata_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (wdata_ld),
    .in    (bus.d_wdata),
    .out   (wdata_q)
  );

  // Writes also load the buffer; its contents are then don't-care.
  register #(.WIDTH(LINE_W)) line_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (line_ld),
    .in    (bus.mem_rdata),
    .out   (line_q)
  );

  // Memory commands depend only on registered state, never on requester inputs.
  assign bus.mem_read  = (state_q == SERVE_I) || ((state_q == SERVE_D) && !wr_q);
  assign bus.mem_write = (state_q == SERVE_D) && wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.i_resp  = (state_q == RESP_I);
  assign bus.d_resp  = (state_q == RESP_D);
  assign bus.i_rdata = line_q;
  assign bus.d_rdata = line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

  cache_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  typedef struct {
    logic [15:0]  addr;
    bit           wr;
    logic [127:0] wdata;
  } mrec_t;

  mrec_t        memq[$];
  mrec_t        cur;
  logic [127:0] mem_arr[logic [15:0]];
  logic [127:0] ref_mem[logic [15:0]];
  bit           busy = 1'b0;
  int           lat_cnt = 0;
  int           force_lat = -1;
  bit           stray_req = 1'b0;
  bit           gap_chk = 1'b0;
  bit           gap_prev = 1'b0;
  int           last_resp_cyc = 0;
  int           cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [127:0] dflt(input logic [15:0] a);
    return {8{a ^ 16'h5A3C}};
  endfunction

  function automatic logic [127:0] env_rd(input logic [15:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return dflt(a);
  endfunction

  function automatic logic [127:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  initial begin : mem_env
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp = 1'b0;
      if (!gap_chk) gap_prev = 1'b0;
      if (busy) begin
        if (bus.mem_read || bus.mem_write) begin
          check_eq("mem_addr_hold", 128'(bus.mem_addr), 128'(cur.addr));
          check_eq("mem_op_hold", 128'(bus.mem_write), 128'(cur.wr));
        end
        if (lat_cnt == 0) begin
          bus.mem_resp = 1'b1;
          if (cur.wr) begin
            mem_arr[cur.addr] = cur.wdata;
            bus.mem_rdata = {4{$urandom}};
          end else begin
            bus.mem_rdata = env_rd(cur.addr);
          end
          busy = 1'b0;
          if (gap_chk) begin
            gap_prev = 1'b1;
            last_resp_cyc = cyc;
          end
        end else begin
          lat_cnt--;
        end
      end else if (bus.mem_read || bus.mem_write) begin
        check_eq("mem_rw_excl", 128'(bus.mem_read & bus.mem_write), 128'd0);
        if (gap_chk && gap_prev)
          check_eq("gap", 128'(cyc - last_resp_cyc), 128'd3);
        cur.addr  = bus.mem_addr;
        cur.wr    = bus.mem_write;
        cur.wdata = bus.mem_wdata;
        memq.push_back(cur);
        busy = 1'b1;
        lat_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end else if (stray_req) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = {4{$urandom}};
        stray_req = 1'b0;
      end
    end
  end

  // ---------------- reference model + transaction driver ----------------
  bit last_d = 1'b0;  // round-robin history: 1 = dcache granted last

  // d_op: 0 read, 1 write, 2 read+write (must be treated as write)
  task automatic serve(input bit want_i, input bit want_d, input int d_op,
                       input logic [15:0] ia, input logic [15:0] da,
                       input logic [127:0] dwd, input bit chg_addr);
    bit order[2];
    int n = 0;
    int k = 0;
    int budget = 0;
    bit d_wr;
    bit who;
    logic [15:0] ea;
    mrec_t r;
    d_wr = (d_op != 0);
    if (want_i && want_d) begin
      order[0] = !last_d;
      order[1] = last_d;
      n = 2;
    end else if (want_i) begin
      order[0] = 1'b0;
      n = 1;
    end else if (want_d) begin
      order[0] = 1'b1;
      n = 1;
    end
    if (n == 0) return;

    bus.i_read  = want_i;
    bus.i_addr  = ia;
    bus.d_read  = want_d && (d_op != 1);
    bus.d_write = want_d && (d_op != 0);
    bus.d_addr  = da;
    bus.d_wdata = dwd;

    @(negedge clk);
    ea = order[0] ? da : ia;
    check_eq("grant_lat", 128'(bus.mem_read | bus.mem_write), 128'd1);
    check_eq("grant_addr", 128'(bus.mem_addr), 128'(ea));
    check_eq("grant_wr", 128'(bus.mem_write), 128'(order[0] && d_wr));

    while (k < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (chg_addr && bus.mem_read) bus.i_addr = ia ^ 16'hFFFF;
      if (bus.i_resp || bus.d_resp) begin
        who = bus.d_resp;
        check_eq("resp_order", 128'(who), 128'(order[k]));
        check_eq("resp_excl", 128'(bus.i_resp & bus.d_resp), 128'd0);
        check_eq("mem_quiet_resp", 128'({bus.mem_read, bus.mem_write}), 128'd0);
        if (order[k]) begin
          if (d_wr) ref_mem[da] = dwd;
          else check_eq("d_rdata", bus.d_rdata, ref_rd(da));
          bus.d_read  = 1'b0;
          bus.d_write = 1'b0;
        end else begin
          check_eq("i_rdata", bus.i_rdata, ref_rd(ia));
          bus.i_read = 1'b0;
        end
        last_d = order[k];
        k++;
      end
    end
    if (k < n) check_eq("resp_timeout", 128'(k), 128'(n));
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;

    @(negedge clk);
    check_eq("resp_single", 128'({bus.i_resp, bus.d_resp}), 128'd0);
    check_eq("idle_after", 128'({bus.mem_read, bus.mem_write}), 128'd0);

    for (int j = 0; j < n; j++) begin
      if (memq.size() == 0) begin
        check_eq("memq_count", 128'(j), 128'(n));
        break;
      end
      r = memq.pop_front();
      check_eq("mem_addr", 128'(r.addr), 128'(order[j] ? da : ia));
      check_eq("mem_write", 128'(r.wr), 128'(order[j] && d_wr));
      if (order[j] && d_wr) check_eq("mem_wdata", r.wdata, dwd);
    end
  endtask

  initial begin : main
    int nres;
    int budget;
    mrec_t r;
    logic [127:0] wd;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_cmds", 128'({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}), 128'd0);
    check_eq("rst_addr", 128'(bus.mem_addr), 128'd0);
    check_eq("rst_wdata", bus.mem_wdata, 128'd0);
    check_eq("rst_rdata", bus.i_rdata | bus.d_rdata, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ties right after reset: dcache first, then the next tie goes to icache first.
    serve(1'b1, 1'b1, 0, 16'h0010, 16'h0020, '0, 1'b0);
    serve(1'b1, 1'b1, 0, 16'h0010, 16'h0020, '0, 1'b0);

    // icache read with fixed 3-cycle memory latency
    mem_arr[16'h1230] = {16{8'hA5}};
    ref_mem[16'h1230] = {16{8'hA5}};
    force_lat = 2;
    serve(1'b1, 1'b0, 0, 16'h1230, '0, '0, 1'b0);
    force_lat = -1;

    // dcache writeback, then read it back
    serve(1'b0, 1'b1, 1, '0, 16'h4000, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    serve(1'b0, 1'b1, 0, '0, 16'h4000, '0, 1'b0);

    // stray mem_resp while idle, then icache address changes mid-service
    stray_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("stray_resp", 128'({bus.i_resp, bus.d_resp}), 128'd0);
      check_eq("stray_cmd", 128'({bus.mem_read, bus.mem_write}), 128'd0);
    end
    force_lat = 3;
    serve(1'b1, 1'b0, 0, 16'h2340, '0, '0, 1'b1);
    force_lat = -1;

    // icache held across three services, dcache idle
    gap_chk = 1'b1;
    nres = 0;
    budget = 0;
    bus.i_addr = 16'h0300;
    bus.i_read = 1'b1;
    while (nres < 3 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (bus.i_resp) begin
        check_eq("b2b_rdata", bus.i_rdata, ref_rd(16'h0300));
        check_eq("b2b_no_d", 128'(bus.d_resp), 128'd0);
        nres++;
        if (nres == 3) bus.i_read = 1'b0;
      end
    end
    if (nres < 3) check_eq("b2b_timeout", 128'(nres), 128'd3);
    bus.i_read = 1'b0;
    last_d = 1'b0;
    @(negedge clk);
    gap_chk = 1'b0;
    check_eq("b2b_count", 128'(memq.size()), 128'd3);
    while (memq.size() > 0) begin
      r = memq.pop_front();
      check_eq("b2b_addr", 128'(r.addr), 128'h0300);
    end

    // reset in the middle of a dcache service, late mem_resp afterwards
    force_lat = 6;
    bus.d_addr = 16'h5550;
    bus.d_read = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.mem_read && budget < 20);
    check_eq("rst_serve_started", 128'(bus.mem_read), 128'd1);
    rst_n = 1'b0;
    bus.d_read = 1'b0;
    #1;
    check_eq("async_rst_cmds", 128'({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}), 128'd0);
    check_eq("async_rst_addr", 128'(bus.mem_addr), 128'd0);
    check_eq("async_rst_rdata", bus.d_rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("late_resp_ignored", 128'({bus.i_resp, bus.d_resp}), 128'd0);
      check_eq("late_resp_cmd", 128'({bus.mem_read, bus.mem_write}), 128'd0);
    end
    memq.delete();
    force_lat = -1;
    last_d = 1'b0;
    // last_grant back at reset value: tie goes to dcache
    serve(1'b1, 1'b1, 0, 16'h0110, 16'h0120, '0, 1'b0);

    // randomized mix, including illegal read+write
    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      wd = {$urandom, $urandom, $urandom, $urandom};
      serve(sel[0], sel[1], int'($urandom_range(0, 2)),
            16'($urandom_range(0, 7) << 4), 16'($urandom_range(0, 7) << 4), wd, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
